soc_arbiter_ahb3: RTL

//  N-master to 1-slave AHB3-Lite arbiter/multiplexer; inverse direction of the AHB3 address decoder.

---
 rtl/soc_arbiter_ahb3_if.sv | 49 ++++
 rtl/soc_arbiter_ahb3.sv | 129 ++++++++++++
 2 files changed

// File: rtl/soc_arbiter_ahb3_if.sv
// Bus bundle for the N-master to 1-slave AHB3-Lite arbiter.
// slave: the arbiter's view; master: the environment (masters plus shared slave) driving it.
interface soc_arbiter_ahb3_if #(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PLEN    = 32
);
  localparam int unsigned SW = XLEN >> 3;

  logic [MASTERS-1:0]           m_hsel_i;
  logic [MASTERS-1:0][PLEN-1:0] m_haddr_i;
  logic [MASTERS-1:0][XLEN-1:0] m_hwdata_i;
  logic [MASTERS-1:0]           m_hwrite_i;
  logic [MASTERS-1:0][2:0]      m_hsize_i;
  logic [MASTERS-1:0][2:0]      m_hburst_i;
  logic [MASTERS-1:0][SW-1:0]   m_hprot_i;
  logic [MASTERS-1:0][1:0]      m_htrans_i;
  logic [MASTERS-1:0]           m_hmastlock_i;
  logic [XLEN-1:0]              m_hrdata_o;
  logic [MASTERS-1:0]           m_hready_o;
  logic [MASTERS-1:0]           m_hresp_o;

  logic                         s_hsel_o;
  logic [PLEN-1:0]              s_haddr_o;
  logic [XLEN-1:0]              s_hwdata_o;
  logic                         s_hwrite_o;
  logic [2:0]                   s_hsize_o;
  logic [2:0]                   s_hburst_o;
  logic [SW-1:0]                s_hprot_o;
  logic [1:0]                   s_htrans_o;
  logic                         s_hmastlock_o;
  logic [XLEN-1:0]              s_hrdata_i;
  logic                         s_hready_i;
  logic                         s_hresp_i;

  modport slave (
    input  m_hsel_i, m_haddr_i, m_hwdata_i, m_hwrite_i, m_hsize_i, m_hburst_i, m_hprot_i,
           m_htrans_i, m_hmastlock_i, s_hrdata_i, s_hready_i, s_hresp_i,
    output m_hrdata_o, m_hready_o, m_hresp_o, s_hsel_o, s_haddr_o, s_hwdata_o, s_hwrite_o,
           s_hsize_o, s_hburst_o, s_hprot_o, s_htrans_o, s_hmastlock_o
  );

  modport master (
    output m_hsel_i, m_haddr_i, m_hwdata_i, m_hwrite_i, m_hsize_i, m_hburst_i, m_hprot_i,
           m_htrans_i, m_hmastlock_i, s_hrdata_i, s_hready_i, s_hresp_i,
    input  m_hrdata_o, m_hready_o, m_hresp_o, s_hsel_o, s_haddr_o, s_hwdata_o, s_hwrite_o,
           s_hsize_o, s_hburst_o, s_hprot_o, s_htrans_o, s_hmastlock_o
  );
endinterface

// File: rtl/soc_arbiter_ahb3.sv
// N-master to 1-slave AHB3-Lite arbiter: round-robin grant at burst boundaries,
// separate address/data-phase ownership for HWDATA and HRESP routing.
module soc_arbiter_ahb3 #(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PLEN    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  soc_arbiter_ahb3_if.slave    ahb
);
  localparam int unsigned MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  logic [MW-1:0]      r_addr_owner;
  logic [MW-1:0]      r_data_owner;
  logic               r_data_valid;
  logic [3:0]         r_beats_left;

  logic [MASTERS-1:0] w_req;
  logic               w_own_busy;
  logic               w_own_active;
  logic [1:0]         w_own_trans;
  logic [2:0]         w_own_burst;
  logic               w_hold;
  logic [3:0]         w_beats_d;
  logic [MW-1:0]      w_next_owner;
  logic               w_found;

  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      w_req[i] = ahb.m_hsel_i[i] & ahb.m_htrans_i[i][1];
    end
  end

  // BUSY keeps the owner's slot on the bus even though it is not a request.
  always_comb begin
    w_own_busy   = ahb.m_hsel_i[r_addr_owner] & (ahb.m_htrans_i[r_addr_owner] == HtransBusy);
    w_own_active = w_req[r_addr_owner] | w_own_busy;
    w_own_trans  = w_own_active ? ahb.m_htrans_i[r_addr_owner] : HtransIdle;
    w_own_burst  = ahb.m_hburst_i[r_addr_owner];
  end

  always_comb begin
    ahb.s_haddr_o     = ahb.m_haddr_i[r_addr_owner];
    ahb.s_hwrite_o    = ahb.m_hwrite_i[r_addr_owner];
    ahb.s_hsize_o     = ahb.m_hsize_i[r_addr_owner];
    ahb.s_hburst_o    = ahb.m_hburst_i[r_addr_owner];
    ahb.s_hprot_o     = ahb.m_hprot_i[r_addr_owner];
    ahb.s_hsel_o      = ~rst_i & w_own_active;
    ahb.s_htrans_o    = rst_i ? HtransIdle : w_own_trans;
    ahb.s_hmastlock_o = ~rst_i & ahb.m_hmastlock_i[r_addr_owner];
    ahb.s_hwdata_o    = ahb.m_hwdata_i[r_data_owner];
    ahb.m_hrdata_o    = ahb.s_hrdata_i;
  end

  always_comb begin
    ahb.m_hready_o = '1;
    ahb.m_hresp_o  = '0;
    if (!rst_i) begin
      for (int unsigned i = 0; i < MASTERS; i++) begin
        if ((r_addr_owner == MW'(i)) || (r_data_valid && (r_data_owner == MW'(i)))) begin
          ahb.m_hready_o[i] = ahb.s_hready_i;
        end else begin
          ahb.m_hready_o[i] = ~w_req[i];
        end
        ahb.m_hresp_o[i] = ahb.s_hresp_i & r_data_valid & (r_data_owner == MW'(i));
      end
    end
  end

  // Burst tracking: a fixed-length burst, an INCR burst, BUSY or a lock keeps the grant.
  always_comb begin
    w_beats_d = r_beats_left;
    w_hold    = ahb.m_hmastlock_i[r_addr_owner];
    case (w_own_trans)
      HtransNonseq: begin
        case (w_own_burst)
          3'b010, 3'b011: w_beats_d = 4'd3;
          3'b100, 3'b101: w_beats_d = 4'd7;
          3'b110, 3'b111: w_beats_d = 4'd15;
          default:        w_beats_d = 4'd0;
        endcase
        if (w_own_burst != 3'b000) w_hold = 1'b1;
      end
      HtransSeq: begin
        if (r_beats_left == 4'd1) begin
          w_beats_d = 4'd0;
        end else begin
          if (r_beats_left != 4'd0) w_beats_d = r_beats_left - 4'd1;
          w_hold = 1'b1;
        end
      end
      HtransBusy: w_hold = 1'b1;
      default:    w_beats_d = 4'd0;
    endcase
  end

  // Scan starts just after the current owner, so the owner has lowest priority.
  always_comb begin
    w_next_owner = r_addr_owner;
    w_found      = 1'b0;
    for (int unsigned j = 1; j <= MASTERS; j++) begin
      if (!w_found && w_req[(32'(r_addr_owner) + j) % MASTERS]) begin
        w_next_owner = MW'((32'(r_addr_owner) + j) % MASTERS);
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr_owner <= '0;
      r_data_owner <= '0;
      r_data_valid <= 1'b0;
      r_beats_left <= 4'd0;
    end else if (ahb.s_hready_i) begin
      r_data_owner <= r_addr_owner;
      r_data_valid <= w_own_trans[1];
      r_beats_left <= w_beats_d;
      if (!w_hold) r_addr_owner <= w_next_owner;
    end
  end
endmodule
